slot_arbiter: RTL

- Time-slot round-robin scheduler that shares one counter-timed resource among N_REQ requesters.
- A CNT_W-bit slot counter bounds each grant to at most SLOT_LEN cycles.
- A one-cycle dead gap separates consecutive grants.
- Sits between requester logic and the shared counter datapath; it sequences who owns the resource and for how long.

---
 rtl/slot_arbiter_pkg.sv | 19 +
 rtl/slot_arbiter_counter.sv | 34 +++
 rtl/slot_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/slot_arbiter_pkg.sv
// Shared definitions for the time-slot round-robin arbiter.
package slot_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_CNT_W    = 3;
  localparam int DEF_SLOT_LEN = 6;

  // Width needed to hold a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slot_arbiter_counter.sv
// Slot length counter: counts cycles inside a grant and flags the last allowed cycle.
module slot_counter
  import slot_arbiter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SLOT_LEN = DEF_SLOT_LEN
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SLOT_LEN - 1);

  logic [CNT_W-1:0] r_count;

  // Clear wins over enable so a slot always starts from zero.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == TC_VAL);

endmodule

// File: rtl/slot_arbiter.sv
// Time-slot round-robin arbiter: one owner at a time, bounded slot length,
// one dead cycle between consecutive grants. All outputs are registered.
module slot_arbiter
  import slot_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SLOT_LEN = DEF_SLOT_LEN,
  localparam int ID_W    = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             busy,
  output logic             timeout
);

  // First requesting index after last, wrapping; caller guarantees r != 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!found && ((r & (N_REQ'(1) << idx)) != '0)) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [ID_W-1:0]  r_grant_id, w_id_nxt;
  logic [ID_W-1:0]  r_last_id, w_last_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_cnt_en, w_cnt_clr;
  logic             w_tc;
  logic [CNT_W-1:0] w_cnt;
  logic             w_e1, w_e2, w_e3;
  logic [ID_W-1:0]  w_pick;

  slot_counter #(
    .CNT_W   (CNT_W),
    .SLOT_LEN(SLOT_LEN)
  ) u_slot_counter (
    .clk    (clk),
    .i_rst_n(reset),
    .i_en   (w_cnt_en),
    .i_clr  (w_cnt_clr),
    .o_count(w_cnt),
    .o_tc   (w_tc)
  );

  // r_grant is the owner's one-hot, so masking with it selects the owner's bits.
  assign w_e1   = |(done & r_grant);
  assign w_e2   = ~|(req & r_grant);
  assign w_e3   = w_tc;
  assign w_pick = rr_pick(req, r_last_id);

  // Next-state and next-output decode; IDLE and GAP arbitrate identically.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_id_nxt      = r_grant_id;
    w_last_nxt    = r_last_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_cnt_en      = 1'b0;
    w_cnt_clr     = 1'b1;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (req != '0) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = N_REQ'(1) << w_pick;
          w_id_nxt    = w_pick;
          w_last_nxt  = w_pick;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_e1 || w_e2 || w_e3) begin
          w_state_nxt   = ST_GAP;
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = w_e3 && !w_e1 && !w_e2;
        end else begin
          w_cnt_en  = 1'b1;
          w_cnt_clr = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; last_id resets so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_last_id  <= ID_W'(N_REQ - 1);
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_id_nxt;
      r_last_id  <= w_last_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign slot_cnt = w_cnt;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule
